// File: rtl/i8088_bus_initiator_if.sv
// Request/response handshake and 8088 minimum-mode bus signals of i8088_bus_initiator.
// The ready wait-state input exists only when I8088_WAIT_EN is defined.
interface i8088_bus_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_addr;
  logic        req_io;
  logic        req_write;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [7:0]  ad_o;
  logic        ad_oe;
  logic [7:0]  ad_i;
  logic [11:0] a;
  logic        ale;
  logic        den_n;
  logic        io_m_n;
  logic        rd_n;
  logic        wr_n;
  logic        dt_r_n;
`ifdef I8088_WAIT_EN
  logic        ready;
`endif

  // master = the bus initiator itself
  modport master (
`ifdef I8088_WAIT_EN
    input  ready,
`endif
    input  req_valid, req_addr, req_io, req_write, req_wdata, ad_i,
    output req_ready, rsp_valid, rsp_rdata,
    output ad_o, ad_oe, a, ale, den_n, io_m_n, rd_n, wr_n, dt_r_n
  );

  modport slave (
`ifdef I8088_WAIT_EN
    output ready,
`endif
    output req_valid, req_addr, req_io, req_write, req_wdata, ad_i,
    input  req_ready, rsp_valid, rsp_rdata,
    input  ad_o, ad_oe, a, ale, den_n, io_m_n, rd_n, wr_n, dt_r_n
  );
endinterface

// File: rtl/i8088_bus_initiator.sv
// i8088 minimum-mode bus-cycle generator: plays single requests out as T1-T4 cycles and
// generates clkcpu. Define I8088_WAIT_EN to add the ready input and TW wait states.
module i8088_bus_initiator #(
  parameter int unsigned CLK_DIV  = 6,
  parameter int unsigned CLK_HIGH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   clkcpu,
  i8088_bus_initiator_if.master  bus
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_TW   = 3'd4,
    S_T4   = 3'd5
  } state_e;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clkcpu_q;
  logic             clkcpu_d;
  logic             tick_s;
  logic             accept_s;
  logic             ready_s;

  state_e           state_q;
  logic             pend_q;
  logic [19:0]      addr_q;
  logic             io_q;
  logic             write_q;
  logic [7:0]       wdata_q;

  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [7:0]       rsp_rdata_q;
  logic [7:0]       ad_o_q;
  logic             ad_oe_q;
  logic [11:0]      a_q;
  logic             ale_q;
  logic             den_n_q;
  logic             io_m_n_q;
  logic             rd_n_q;
  logic             wr_n_q;
  logic             dt_r_n_q;

`ifdef I8088_WAIT_EN
  assign ready_s = bus.ready;
`else
  assign ready_s = 1'b1;
`endif

  // tick marks the last clk of a clkcpu period, so state changes line up with clkcpu rising
  always_comb begin
    cnt_d    = cnt_q;
    clkcpu_d = clkcpu_q;
    tick_s   = (cnt_q == CNT_W'(CLK_DIV - 1));
    if (tick_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    clkcpu_d = (cnt_d < CNT_W'(CLK_HIGH));
  end

  // Divider registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= {CNT_W{1'b0}};
      clkcpu_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      clkcpu_q <= clkcpu_d;
    end
  end

  assign accept_s = bus.req_valid & req_ready_q;

  // Bus FSM and all registered bus strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pend_q      <= 1'b0;
      addr_q      <= 20'h00000;
      io_q        <= 1'b0;
      write_q     <= 1'b0;
      wdata_q     <= 8'h00;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      ad_o_q      <= 8'h00;
      ad_oe_q     <= 1'b0;
      a_q         <= 12'h000;
      ale_q       <= 1'b0;
      den_n_q     <= 1'b1;
      io_m_n_q    <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      dt_r_n_q    <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;

      // req_ready is low whenever a request is pending, so this never collides with T1 entry
      if (accept_s) begin
        pend_q      <= 1'b1;
        req_ready_q <= 1'b0;
        addr_q      <= bus.req_addr;
        io_q        <= bus.req_io;
        write_q     <= bus.req_write;
        wdata_q     <= bus.req_wdata;
      end

      if (tick_s) begin
        case (state_q)
          S_IDLE: begin
            if (pend_q) begin
              state_q  <= S_T1;
              pend_q   <= 1'b0;
              ale_q    <= 1'b1;
              ad_o_q   <= addr_q[7:0];
              ad_oe_q  <= 1'b1;
              a_q      <= addr_q[19:8];
              io_m_n_q <= io_q;
              dt_r_n_q <= write_q;
            end
          end
          S_T1: begin
            state_q <= S_T2;
            ale_q   <= 1'b0;
            den_n_q <= 1'b0;
            if (write_q) begin
              wr_n_q  <= 1'b0;
              ad_o_q  <= wdata_q;
              ad_oe_q <= 1'b1;
            end else begin
              rd_n_q  <= 1'b0;
              ad_oe_q <= 1'b0;
            end
          end
          S_T2: begin
            state_q <= S_T3;
          end
          S_T3, S_TW: begin
            if (ready_s) begin
              state_q     <= S_T4;
              rsp_valid_q <= 1'b1;
              if (!write_q) begin
                rsp_rdata_q <= bus.ad_i;
              end
              rd_n_q  <= 1'b1;
              wr_n_q  <= 1'b1;
              den_n_q <= 1'b1;
              ad_oe_q <= 1'b0;
            end else begin
              state_q <= S_TW;
            end
          end
          S_T4: begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
          end
          default: begin
            state_q     <= S_IDLE;
            pend_q      <= 1'b0;
            req_ready_q <= 1'b1;
            ale_q       <= 1'b0;
            den_n_q     <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            ad_oe_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign clkcpu        = clkcpu_q;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.ad_o      = ad_o_q;
  assign bus.ad_oe     = ad_oe_q;
  assign bus.a         = a_q;
  assign bus.ale       = ale_q;
  assign bus.den_n     = den_n_q;
  assign bus.io_m_n    = io_m_n_q;
  assign bus.rd_n      = rd_n_q;
  assign bus.wr_n      = wr_n_q;
  assign bus.dt_r_n    = dt_r_n_q;

endmodule

// File: tb/tb_i8088_bus_initiator.sv
// Self-checking bench for i8088_bus_initiator: expected bus activity is derived from the
// clk count since reset (6 clk per clkcpu period) and the transaction being played.
module tb_i8088_bus_initiator;
  logic clk = 1'b0;
  logic rst_n;
  logic clkcpu;

  i8088_bus_initiator_if bus ();

  i8088_bus_initiator #(.CLK_DIV(6), .CLK_HIGH(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clkcpu (clkcpu),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // k = number of rising clk edges since reset release
  int k;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  int checks = 0;
  int errors = 0;

  logic        tx_io, tx_wr;
  logic [19:0] tx_addr;
  logic [7:0]  tx_wd;
  logic [11:0] cur_a;
  logic        cur_io, cur_dt;
  logic [7:0]  rd_model;
  int          t1_k, done_k;

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // ph: 0 idle, 1 accepted/waiting for T1, 2 T1, 3 T2/T3/TW, 4 T4
  task automatic check_bus(input int ph);
    chk("clkcpu",    clkcpu,        ((k % 6) < 2));
    chk("req_ready", bus.req_ready, (ph == 0));
    chk("ale",       bus.ale,       (ph == 2));
    chk("den_n",     bus.den_n,     (ph != 3));
    chk("rd_n",      bus.rd_n,      !(ph == 3 && !tx_wr));
    chk("wr_n",      bus.wr_n,      !(ph == 3 && tx_wr));
    chk("ad_oe",     bus.ad_oe,     (ph == 2) || (ph == 3 && tx_wr));
    if (ph == 2) chk("ad_o_addr", bus.ad_o, tx_addr[7:0]);
    if (ph == 3 && tx_wr) chk("ad_o_wdata", bus.ad_o, tx_wd);
    chk("a",         bus.a,         cur_a);
    chk("io_m_n",    bus.io_m_n,    cur_io);
    chk("dt_r_n",    bus.dt_r_n,    cur_dt);
    chk("rsp_valid", bus.rsp_valid, (ph == 4 && k == done_k));
    chk("rsp_rdata", bus.rsp_rdata, rd_model);
  endtask

  // Inputs seen by edge e: read data only matters on the completion edge
  task automatic drive_inputs(input int e, input logic [7:0] rdv);
    if (e == done_k) bus.ad_i = rdv;
    else             bus.ad_i = 8'($urandom);
`ifdef I8088_WAIT_EN
    if (e >= t1_k + 18 && ((e - t1_k) % 6) == 0) bus.ready = (e >= done_k);
    else                                         bus.ready = 1'($urandom);
`endif
  endtask

  task automatic idle_clks(input int n);
    repeat (n) begin
      @(negedge clk);
      check_bus(0);
`ifdef I8088_WAIT_EN
      bus.ready = 1'($urandom);
`endif
    end
  endtask

  // Play one request from an idle negedge; w = wait states, stop_off >= 0 aborts at t1+stop_off
  task automatic run_txn(input logic io, input logic wr, input logic [19:0] addr,
                         input logic [7:0] wd, input logic [7:0] rdv, input int w,
                         input logic hold, input int stop_off);
    int acc, idle, ph;
    chk("ready_before_req", bus.req_ready, 1'b1);
    tx_io = io; tx_wr = wr; tx_addr = addr; tx_wd = wd;
    bus.req_valid = 1'b1;
    bus.req_io    = io;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    acc    = k + 1;
    t1_k   = (acc / 6 + 1) * 6;
    done_k = t1_k + 18 + 6 * w;
    idle   = done_k + 6;
    drive_inputs(acc, rdv);
    do begin
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
      if (k >= t1_k) begin
        cur_a  = addr[19:8];
        cur_io = io;
        cur_dt = wr;
      end
      if (k == done_k && !wr) rd_model = rdv;
      if (k < t1_k)           ph = 1;
      else if (k < t1_k + 6)  ph = 2;
      else if (k < done_k)    ph = 3;
      else if (k < idle)      ph = 4;
      else                    ph = 0;
      check_bus(ph);
      drive_inputs(k + 1, rdv);
    end while (k < idle && !(stop_off >= 0 && k == t1_k + stop_off));
  endtask

  task automatic apply_reset_model();
    cur_a    = 12'h000;
    cur_io   = 1'b0;
    cur_dt   = 1'b1;
    rd_model = 8'h00;
    t1_k     = -100;
    done_k   = -100;
    tx_wr    = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_io    = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 20'h00000;
    bus.req_wdata = 8'h00;
    bus.ad_i      = 8'h00;
`ifdef I8088_WAIT_EN
    bus.ready     = 1'b1;
`endif
    apply_reset_model();
    tx_io = 1'b0; tx_addr = 20'h00000; tx_wd = 8'h00;

    #1 rst_n = 1'b0;
    #1 check_bus(0);
    chk("reset_ad_o", bus.ad_o, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // idle after reset: clkcpu 6/2 pattern, strobes at rest
    idle_clks(100);

    // memory write 0x12345 <- 0xA5
    run_txn(1'b0, 1'b1, 20'h12345, 8'hA5, 8'h00, 0, 1'b0, -1);
    idle_clks(2);

    // IO read 0x003F8 returning 0x5A, then rsp_rdata must hold with ad_i = 0
    run_txn(1'b1, 1'b0, 20'h003F8, 8'h00, 8'h5A, 0, 1'b0, -1);
    bus.ad_i = 8'h00;
    idle_clks(10);

    // req_valid held high across two requests: no overlap, no T4->T1
    run_txn(1'b0, 1'b1, 20'hABCDE, 8'h3C, 8'h00, 0, 1'b1, -1);
    run_txn(1'b1, 1'b0, 20'h0F0F0, 8'h00, 8'h96, 0, 1'b0, -1);
    idle_clks(1);

    // reset in the middle of T2 of a read
    run_txn(1'b0, 1'b0, 20'h00100, 8'h00, 8'h77, 0, 1'b0, 8);
    #2 rst_n = 1'b0;
    #1 apply_reset_model();
    check_bus(0);
    chk("midreset_ad_o", bus.ad_o, 8'h00);
    repeat (3) begin
      @(negedge clk);
      check_bus(0);
    end
    rst_n = 1'b1;
    idle_clks(4);
    run_txn(1'b0, 1'b0, 20'h2A5C3, 8'h00, 8'hC3, 0, 1'b0, -1);
    idle_clks(3);

`ifdef I8088_WAIT_EN
    // three TW states on the IO read
    run_txn(1'b1, 1'b0, 20'h003F8, 8'h00, 8'h5A, 3, 1'b0, -1);
    idle_clks(2);
`endif

    // randomized requests
    repeat (10) begin
      int w;
`ifdef I8088_WAIT_EN
      w = $urandom_range(0, 2);
`else
      w = 0;
`endif
      idle_clks($urandom_range(0, 7));
      run_txn(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom), 8'($urandom),
              w, 1'b0, -1);
    end
    idle_clks(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
